// File: rtl/match_pkg.sv
// Shared types and widths for the Pong match sequencer.
// The state codes double as the LED encoding on state_code.
package match_pkg;

   localparam int FRAME_W = 7;
   localparam int DEB_W   = 4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SERVE  = 3'd1,
      S_PLAY   = 3'd2,
      S_POINT  = 3'd3,
      S_OVER   = 3'd4,
      S_PAUSED = 3'd5
   } state_t;

endpackage

// File: rtl/frame_debounce.sv
// One key: 2-flop synchroniser, frame-rate sampling and a single press pulse.
// A press needs a high sample first, so a held key fires only once.
module frame_debounce #(
   parameter int DEBOUNCE_FRAMES = 3
) (
   input  logic clock,
   input  logic reset_n,
   input  logic key_n,
   input  logic frame_tick,
   output logic press
);
   import match_pkg::*;

   localparam logic [DEB_W-1:0] LAST = DEB_W'(DEBOUNCE_FRAMES - 1);

   logic             key_s1;
   logic             key_s2;
   logic             armed;
   logic [DEB_W-1:0] low_cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         key_s1  <= 1'b0;
         key_s2  <= 1'b0;
         armed   <= 1'b0;
         low_cnt <= '0;
         press   <= 1'b0;
      end else begin
         key_s1 <= key_n;
         key_s2 <= key_s1;
         press  <= 1'b0;
         if (frame_tick) begin
            if (key_s2) begin
               armed   <= 1'b1;
               low_cnt <= '0;
            end else if (armed) begin
               if (low_cnt == LAST) begin
                  press   <= 1'b1;
                  armed   <= 1'b0;
                  low_cnt <= '0;
               end else begin
                  low_cnt <= low_cnt + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/match_ctrl.sv
// Pong match sequencer: frame ticks from vsync, debounced keys, scores and ball control.
// Build with MATCH_CTRL_PAUSE_EN to add the PAUSED state and the pause key debouncer.
module match_ctrl #(
   parameter int WIN_SCORE       = 7,
   parameter int SERVE_FRAMES    = 60,
   parameter int POINT_FRAMES    = 90,
   parameter int DEBOUNCE_FRAMES = 3
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       vsync,
   input  logic       start_n,
   input  logic       pause_n,
   input  logic       goal_left,
   input  logic       goal_right,
   output logic       ball_run,
   output logic       ball_reset,
   output logic       serve_dir,
   output logic [3:0] score_left,
   output logic [3:0] score_right,
   output logic       game_over,
   output logic       winner,
   output logic [2:0] state_code
);
   import match_pkg::*;

   localparam logic [FRAME_W-1:0] SERVE_LAST = FRAME_W'(SERVE_FRAMES - 1);
   localparam logic [FRAME_W-1:0] POINT_LAST = FRAME_W'(POINT_FRAMES - 1);
   localparam logic [3:0]         WIN        = 4'(WIN_SCORE);

   logic               vs_s1;
   logic               vs_s2;
   logic               vs_d;
   logic               frame_tick;
   logic               start_press;
   logic               pause_press;
   logic [FRAME_W-1:0] frame_cnt;
   state_t             state;
   state_t             nxt;

   assign frame_tick = vs_d & ~vs_s2;
   assign state_code = state;

   frame_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_start (
      .clock      (clock),
      .reset_n    (reset_n),
      .key_n      (start_n),
      .frame_tick (frame_tick),
      .press      (start_press)
   );

`ifdef MATCH_CTRL_PAUSE_EN
   frame_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_pause (
      .clock      (clock),
      .reset_n    (reset_n),
      .key_n      (pause_n),
      .frame_tick (frame_tick),
      .press      (pause_press)
   );
`else
   logic pause_unused;
   assign pause_unused = pause_n;
   assign pause_press  = 1'b0;
`endif

   // A goal takes priority over a pause press arriving in the same cycle.
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:   if (start_press) nxt = S_SERVE;
         S_SERVE:  if (frame_tick && frame_cnt == SERVE_LAST) nxt = S_PLAY;
         S_PLAY: begin
            if (goal_left || goal_right) nxt = S_POINT;
            else if (pause_press)        nxt = S_PAUSED;
         end
         S_POINT: begin
            if (frame_tick && frame_cnt == POINT_LAST)
               nxt = (score_left == WIN || score_right == WIN) ? S_OVER : S_SERVE;
         end
         S_OVER:   if (start_press) nxt = S_SERVE;
         S_PAUSED: if (pause_press) nxt = S_PLAY;
         default:  nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they change together with state_code.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vs_s1       <= 1'b0;
         vs_s2       <= 1'b0;
         vs_d        <= 1'b0;
         state       <= S_IDLE;
         frame_cnt   <= '0;
         ball_run    <= 1'b0;
         ball_reset  <= 1'b1;
         serve_dir   <= 1'b0;
         score_left  <= 4'd0;
         score_right <= 4'd0;
         game_over   <= 1'b0;
         winner      <= 1'b0;
      end else begin
         vs_s1 <= vsync;
         vs_s2 <= vs_s1;
         vs_d  <= vs_s2;
         state <= nxt;

         if (nxt != state)
            frame_cnt <= '0;
         else if (frame_tick && state != S_PAUSED)
            frame_cnt <= frame_cnt + 1'b1;

         ball_run   <= (nxt == S_PLAY);
         ball_reset <= (nxt == S_IDLE) || (nxt == S_SERVE) || (nxt == S_OVER);
         game_over  <= (nxt == S_OVER);

         // The serve goes to whoever conceded; a double goal is a let.
         if (state == S_PLAY && goal_right && !goal_left) begin
            if (score_left != WIN) score_left <= score_left + 4'd1;
            serve_dir <= 1'b0;
         end else if (state == S_PLAY && goal_left && !goal_right) begin
            if (score_right != WIN) score_right <= score_right + 4'd1;
            serve_dir <= 1'b1;
         end

         if (nxt == S_OVER && state != S_OVER)
            winner <= (score_right == WIN);

         if (state == S_OVER && nxt == S_SERVE) begin
            score_left  <= 4'd0;
            score_right <= 4'd0;
         end
      end
   end

endmodule

// File: tb/tb_match_ctrl.sv
// Self-checking bench for match_ctrl against a rule-level match model.
// Honours MATCH_CTRL_PAUSE_EN the same way as the design.
module tb_match_ctrl;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       vsync = 1'b1;
   logic       start_n = 1'b1;
   logic       pause_n = 1'b1;
   logic       goal_left = 1'b0;
   logic       goal_right = 1'b0;
   logic       ball_run;
   logic       ball_reset;
   logic       serve_dir;
   logic [3:0] score_left;
   logic [3:0] score_right;
   logic       game_over;
   logic       winner;
   logic [2:0] state_code;

   int total = 0;
   int bad = 0;

   int m_left = 0;
   int m_right = 0;
   int m_dir = 0;
   int m_state = 0;
   int m_winner = 0;

   match_ctrl dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .vsync       (vsync),
      .start_n     (start_n),
      .pause_n     (pause_n),
      .goal_left   (goal_left),
      .goal_right  (goal_right),
      .ball_run    (ball_run),
      .ball_reset  (ball_reset),
      .serve_dir   (serve_dir),
      .score_left  (score_left),
      .score_right (score_right),
      .game_over   (game_over),
      .winner      (winner),
      .state_code  (state_code)
   );

   always #5 clock = ~clock;

   // Free-running frame: 12 cycles high, 4 cycles low.
   initial begin
      forever begin
         repeat (12) @(negedge clock);
         vsync = 1'b0;
         repeat (4) @(negedge clock);
         vsync = 1'b1;
      end
   end

   task automatic mid_frame();
      @(negedge vsync);
      repeat (8) @(negedge clock);
   endtask

   task automatic wait_frames(input int n);
      repeat (n) mid_frame();
   endtask

   task automatic hold_start(input int n);
      mid_frame();
      start_n = 1'b0;
      wait_frames(n);
      start_n = 1'b1;
   endtask

   task automatic hold_pause(input int n);
      mid_frame();
      pause_n = 1'b0;
      wait_frames(n);
      pause_n = 1'b1;
   endtask

   task automatic model_goal(input bit gl, input bit gr);
      if (gr && !gl) begin
         if (m_left < 7) m_left++;
         m_dir = 0;
      end else if (gl && !gr) begin
         if (m_right < 7) m_right++;
         m_dir = 1;
      end
   endtask

   // One rally from a fresh SERVE entry through the POINT freeze.
   task automatic run_point(input bit gl, input bit gr, input bit stray);
      if (stray) begin
         wait_frames(20);
         goal_left = $urandom_range(0, 1);
         goal_right = ~goal_left;
         @(negedge clock);
         goal_left = 1'b0;
         goal_right = 1'b0;
         total++;
         if (score_left !== 4'(m_left) || score_right !== 4'(m_right) || state_code !== 3'd1) begin
            bad++;
            $display("[TB] FAIL serve_goal_ignored: got L=%0d R=%0d st=%0d want L=%0d R=%0d st=1",
                     score_left, score_right, state_code, m_left, m_right);
         end
         wait_frames(39);
      end else begin
         wait_frames(59);
      end
      total++;
      if (state_code !== 3'd1 || ball_reset !== 1'b1 || ball_run !== 1'b0) begin
         bad++;
         $display("[TB] FAIL serve_hold: got st=%0d rst=%0d run=%0d want st=1 rst=1 run=0",
                  state_code, ball_reset, ball_run);
      end
      wait_frames(1);
      total++;
      if (state_code !== 3'd2 || ball_run !== 1'b1 || ball_reset !== 1'b0) begin
         bad++;
         $display("[TB] FAIL serve_to_play: got st=%0d run=%0d rst=%0d want st=2 run=1 rst=0",
                  state_code, ball_run, ball_reset);
      end
      repeat ($urandom_range(0, 4)) @(negedge clock);
      goal_left = gl;
      goal_right = gr;
      @(negedge clock);
      goal_left = 1'b0;
      goal_right = 1'b0;
      model_goal(gl, gr);
      total++;
      if (score_left !== 4'(m_left) || score_right !== 4'(m_right) || serve_dir !== 1'(m_dir) ||
          state_code !== 3'd3 || ball_run !== 1'b0 || ball_reset !== 1'b0) begin
         bad++;
         $display("[TB] FAIL goal_update: got L=%0d R=%0d dir=%0d st=%0d run=%0d rst=%0d want L=%0d R=%0d dir=%0d st=3 run=0 rst=0",
                  score_left, score_right, serve_dir, state_code, ball_run, ball_reset,
                  m_left, m_right, m_dir);
      end
      wait_frames(89);
      total++;
      if (state_code !== 3'd3) begin
         bad++;
         $display("[TB] FAIL point_hold: got st=%0d want st=3", state_code);
      end
      wait_frames(1);
      m_state = (m_left == 7 || m_right == 7) ? 4 : 1;
      m_winner = (m_right == 7) ? 1 : 0;
      total++;
      if (state_code !== 3'(m_state)) begin
         bad++;
         $display("[TB] FAIL point_exit: got st=%0d want st=%0d", state_code, m_state);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (4) @(negedge clock);
      total++;
      if (state_code !== 3'd0 || ball_run !== 1'b0 || ball_reset !== 1'b1 || serve_dir !== 1'b0 ||
          score_left !== 4'd0 || score_right !== 4'd0 || game_over !== 1'b0 || winner !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_values: got st=%0d run=%0d rst=%0d dir=%0d L=%0d R=%0d go=%0d win=%0d want 0 0 1 0 0 0 0 0",
                  state_code, ball_run, ball_reset, serve_dir, score_left, score_right, game_over, winner);
      end
      reset_n = 1'b1;
      wait_frames(3);
      total++;
      if (state_code !== 3'd0) begin
         bad++;
         $display("[TB] FAIL idle_stays: got st=%0d want st=0", state_code);
      end
   endtask

   task automatic test_glitch();
      hold_start($urandom_range(1, 2));
      wait_frames(4);
      total++;
      if (state_code !== 3'd0) begin
         bad++;
         $display("[TB] FAIL short_press_ignored: got st=%0d want st=0", state_code);
      end
   endtask

   task automatic test_start();
      hold_start(3);
      m_state = 1;
      total++;
      if (state_code !== 3'd1 || ball_reset !== 1'b1 || ball_run !== 1'b0) begin
         bad++;
         $display("[TB] FAIL start_press: got st=%0d rst=%0d run=%0d want st=1 rst=1 run=0",
                  state_code, ball_reset, ball_run);
      end
   endtask

   task automatic test_goal();
      run_point(1'b0, 1'b1, 1'b1);
   endtask

   task automatic test_let();
      run_point(1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_win();
      int guard = 0;
      bit gr;
      while (m_state != 4 && guard < 30) begin
         gr = ($urandom_range(0, 2) != 0);
         run_point(~gr, gr, 1'b0);
         guard++;
      end
      total++;
      if (game_over !== 1'b1 || winner !== 1'(m_winner) || state_code !== 3'd4 ||
          ball_reset !== 1'b1 || ball_run !== 1'b0) begin
         bad++;
         $display("[TB] FAIL game_over: got go=%0d win=%0d st=%0d rst=%0d run=%0d want go=1 win=%0d st=4 rst=1 run=0",
                  game_over, winner, state_code, ball_reset, ball_run, m_winner);
      end
      hold_start(3);
      m_left = 0;
      m_right = 0;
      m_state = 1;
      total++;
      if (state_code !== 3'd1 || score_left !== 4'd0 || score_right !== 4'd0 ||
          serve_dir !== 1'(m_dir) || game_over !== 1'b0) begin
         bad++;
         $display("[TB] FAIL restart: got st=%0d L=%0d R=%0d dir=%0d go=%0d want st=1 L=0 R=0 dir=%0d go=0",
                  state_code, score_left, score_right, serve_dir, game_over, m_dir);
      end
   endtask

   task automatic test_pause();
      wait_frames(60);
      total++;
      if (state_code !== 3'd2) begin
         bad++;
         $display("[TB] FAIL pause_setup: got st=%0d want st=2", state_code);
      end
      hold_pause(3);
`ifdef MATCH_CTRL_PAUSE_EN
      total++;
      if (state_code !== 3'd5 || ball_run !== 1'b0) begin
         bad++;
         $display("[TB] FAIL pause_enter: got st=%0d run=%0d want st=5 run=0", state_code, ball_run);
      end
      goal_right = 1'b1;
      @(negedge clock);
      goal_right = 1'b0;
      total++;
      if (score_left !== 4'(m_left) || state_code !== 3'd5) begin
         bad++;
         $display("[TB] FAIL paused_goal_ignored: got L=%0d st=%0d want L=%0d st=5",
                  score_left, state_code, m_left);
      end
      hold_pause(3);
      total++;
      if (state_code !== 3'd2 || ball_run !== 1'b1) begin
         bad++;
         $display("[TB] FAIL pause_resume: got st=%0d run=%0d want st=2 run=1", state_code, ball_run);
      end
`else
      total++;
      if (state_code !== 3'd2 || ball_run !== 1'b1) begin
         bad++;
         $display("[TB] FAIL pause_disabled: got st=%0d run=%0d want st=2 run=1", state_code, ball_run);
      end
`endif
      goal_right = 1'b1;
      @(negedge clock);
      goal_right = 1'b0;
      model_goal(1'b0, 1'b1);
      total++;
      if (score_left !== 4'(m_left) || state_code !== 3'd3) begin
         bad++;
         $display("[TB] FAIL goal_after_pause: got L=%0d st=%0d want L=%0d st=3",
                  score_left, state_code, m_left);
      end
   endtask

   task automatic test_reset_mid();
      wait_frames(10);
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if (state_code !== 3'd0 || ball_run !== 1'b0 || ball_reset !== 1'b1 || serve_dir !== 1'b0 ||
          score_left !== 4'd0 || score_right !== 4'd0 || game_over !== 1'b0 || winner !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_mid_point: got st=%0d run=%0d rst=%0d dir=%0d L=%0d R=%0d go=%0d win=%0d want 0 0 1 0 0 0 0 0",
                  state_code, ball_run, ball_reset, serve_dir, score_left, score_right, game_over, winner);
      end
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      wait_frames(2);
      total++;
      if (state_code !== 3'd0) begin
         bad++;
         $display("[TB] FAIL reset_release_idle: got st=%0d want st=0", state_code);
      end
   endtask

   initial begin
      $display("[TB] match_ctrl bench starting");
      test_reset();
      test_glitch();
      test_start();
      test_goal();
      test_let();
      test_win();
      test_pause();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
